or_bus_driver: RTL
==================

// Module: or_bus_driver
// PURPOSE
//  Upstream master for the address-mapped OR engine (regs: 0 a_full_n, 1 b_full_n, 2 y_empty_n, 3 y_data, 4 a_data, 5 b_data).
//  Accepts operand pairs on a valid/ready stream and writes them to addr 4/5.
//  Polls y_empty_n, pops the result from addr 3 and returns it on a valid/ready result stream.
//  One transaction in flight; this block is the only master on the engine's write/read ports.
// PARAMETERS
//  DATA_W        8     operand/result/bus data width
//  ADDR_W        3     bus address width
//  POLL_TIMEOUT  1023  max consecutive unsuccessful poll cycles per poll state (>=2); engine produces every 256 cycles
// PORTS
//  CLK            in   1       clock, all logic on posedge
//  RST            in   1       synchronous reset, active-high
//  in_valid       in   1       operand pair valid
//  in_ready       out  1       operand pair accepted when in_valid&in_ready
//  in_a           in   DATA_W  operand A
//  in_b           in   DATA_W  operand B
//  out_valid      out  1       result valid
//  out_ready      in   1       result consumed when out_valid&out_ready
//  out_y          out  DATA_W  result (engine addr 3 data)
//  write_address  out  ADDR_W  engine write address
//  write_data     out  DATA_W  engine write data
//  write_en       out  1       engine write strobe
//  write_rdy      in   1       engine write ready
//  read_address   out  ADDR_W  engine read address (engine read_data is combinational on it)
//  read_en        out  1       engine read strobe; high only for the addr-3 pop
//  read_data      in   DATA_W  engine read data, same cycle
//  read_rdy       in   1       engine read ready
//  busy           out  1       FSM not in IDLE
//  timeout_err    out  1       sticky: a poll state timed out
//  check_err      out  1       sticky: result mismatch (OR_DRV_CHECK_EN only)
//  mismatch_cnt   out  8       saturating mismatch count (OR_DRV_CHECK_EN only)
// BEHAVIOUR
//  Reset (sync, RST=1): state IDLE, every output and operand/result reg 0; in-flight txn abandoned; timer 0.
//  IDLE: in_ready=1; on in_valid latch in_a/in_b -> POLL_A. in_ready=0 in every other state.
//  POLL_A: read_address=0, read_en=0; if read_rdy & read_data[0] -> WR_A, else timer++.
//  WR_A: write_address=4, write_data=a, write_en=write_rdy; on write_rdy -> POLL_B (write lasts exactly one cycle).
//  POLL_B: read_address=1; bit0=1 & read_rdy -> WR_B. WR_B: addr 5, data b, as WR_A -> POLL_Y.
//  POLL_Y: read_address=2; bit0=1 & read_rdy -> RD_Y.
//  RD_Y: read_address=3, read_en=read_rdy; on read_rdy capture read_data into out_y -> OUT. Exactly one pop per txn.
//  OUT: out_valid=1, out_y stable; on out_ready -> IDLE (next operand accepted >=1 cycle later; no bypass).
//  Latency in->out with always-ready engine/sink: 7 cycles + POLL_Y wait.
//  Timer: cleared on every state entry; when it reaches POLL_TIMEOUT in any POLL state -> timeout_err<=1, txn dropped, -> IDLE.
//  Timeout after WR_A/WR_B leaves data in engine; recovery is by RST only. timeout_err cleared only by RST.
//  Bus outputs not named in a state are driven 0 (addr 0, data 0, strobes 0).
//  RST mid-transaction has priority over every state action in the same cycle.
// CONFIGURATION
//  OR_DRV_CHECK_EN defined: in RD_Y compare captured data with a|b; mismatch -> check_err<=1 (sticky),
//   mismatch_cnt++ saturating at 255; result still forwarded unchanged.
//  Not defined: no compare logic; check_err and mismatch_cnt tied 0; ports remain.
// STRUCTURE
//  Package or_drv_pkg: state enum (IDLE,POLL_A,WR_A,POLL_B,WR_B,POLL_Y,RD_Y,OUT), register address
//   constants (REG_A_FULLN=0, REG_B_FULLN=1, REG_Y_EMPTYN=2, REG_Y_DATA=3, REG_A_DATA=4, REG_B_DATA=5).
//  Sub-module or_drv_poll_timer: clear/inc/expired counter, width $clog2(POLL_TIMEOUT+1).
// TESTING (bench instantiates this block driving the OR engine, or a register model)
//  1 in_a=0x0F,in_b=0xF0, sink ready -> out_y=0xFF; bus log: wr@4=0x0F, wr@5=0xF0, one read_en@3; busy falls after accept.
//  2 out_ready=0 for 10 cycles in OUT -> out_valid=1, out_y constant, in_ready=0; on out_ready=1 -> IDLE next cycle.
//  3 model: addr0 bit0=0 for 20 cycles -> no write_en during those cycles; wr@4 on cycle after bit0=1.
//  4 POLL_TIMEOUT=16, addr2 stuck 0 -> timeout_err=1 after 16 POLL_Y cycles, state IDLE, in_ready=1, no read_en pulse.
//  5 RST=1 for one cycle while in POLL_Y -> next cycle all outputs 0, busy=0; fresh txn 0x01|0x02 -> out_y=0x03.
//  6 OR_DRV_CHECK_EN, model returns 0x00 at addr3 for 0x01|0x02 -> out_y=0x00, check_err=1, mismatch_cnt=1.

Source files
------------

// File: rtl/or_drv_pkg.sv
// Shared types and register map for the OR-engine bus driver.
package or_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POLL_A,
    WR_A,
    POLL_B,
    WR_B,
    POLL_Y,
    RD_Y,
    OUT
  } drv_state_t;

  localparam int unsigned REG_A_FULLN  = 0;
  localparam int unsigned REG_B_FULLN  = 1;
  localparam int unsigned REG_Y_EMPTYN = 2;
  localparam int unsigned REG_Y_DATA   = 3;
  localparam int unsigned REG_A_DATA   = 4;
  localparam int unsigned REG_B_DATA   = 5;

  function automatic logic is_poll(input drv_state_t s);
    return (s == POLL_A) || (s == POLL_B) || (s == POLL_Y);
  endfunction

endpackage

// File: rtl/or_drv_poll_timer.sv
// Poll-cycle counter: counts unsuccessful polls, flags the last allowed one.
module or_drv_poll_timer #(
  parameter int unsigned LIMIT = 1023
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  // Asserted during the LIMIT-th consecutive poll cycle of a state.
  assign expired = (count >= LAST);

endmodule

// File: rtl/or_bus_driver.sv
// Bus master feeding operand pairs to the OR engine and returning its result.
// Optional result self-check enabled by defining OR_DRV_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for an operand pair
// POLL_A | waiting for engine A slot free (addr 0 bit0)
// WR_A   | writing operand A to addr 4
// POLL_B | waiting for engine B slot free (addr 1 bit0)
// WR_B   | writing operand B to addr 5
// POLL_Y | waiting for result available (addr 2 bit0)
// RD_Y   | popping result from addr 3
// OUT    | presenting result to the sink
module or_bus_driver
  import or_drv_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned POLL_TIMEOUT = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en,
  input  logic              write_rdy,
  output logic [ADDR_W-1:0] read_address,
  output logic              read_en,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_rdy,
  output logic              busy,
  output logic              timeout_err,
  output logic              check_err,
  output logic [7:0]        mismatch_cnt
);

  drv_state_t        state;
  drv_state_t        nxt;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              poll_ok;
  logic              in_poll;
  logic              tmr_inc;
  logic              tmr_clr;
  logic              tmr_expired;
  logic              timeout_hit;

  or_drv_poll_timer #(
    .LIMIT (POLL_TIMEOUT)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (tmr_clr),
    .inc     (tmr_inc),
    .expired (tmr_expired)
  );

  // Timer only runs through unsuccessful poll cycles, so it is zero on every state entry.
  always_comb begin
    poll_ok     = read_rdy && read_data[0];
    in_poll     = is_poll(state);
    tmr_inc     = in_poll && !poll_ok && !tmr_expired;
    tmr_clr     = !tmr_inc;
    timeout_hit = in_poll && !poll_ok && tmr_expired;
    nxt         = state;
    case (state)
      IDLE:   if (in_valid && in_ready) nxt = POLL_A;
      POLL_A: if (poll_ok) nxt = WR_A;   else if (tmr_expired) nxt = IDLE;
      WR_A:   if (write_rdy) nxt = POLL_B;
      POLL_B: if (poll_ok) nxt = WR_B;   else if (tmr_expired) nxt = IDLE;
      WR_B:   if (write_rdy) nxt = POLL_Y;
      POLL_Y: if (poll_ok) nxt = RD_Y;   else if (tmr_expired) nxt = IDLE;
      RD_Y:   if (read_rdy) nxt = OUT;
      OUT:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign write_en = ((state == WR_A) || (state == WR_B)) && write_rdy;
  assign read_en  = (state == RD_Y) && read_rdy;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      out_y         <= '0;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      out_valid     <= 1'b0;
      read_address  <= '0;
      write_address <= '0;
      write_data    <= '0;
      timeout_err   <= 1'b0;
    end else begin
      state     <= nxt;
      in_ready  <= (nxt == IDLE);
      busy      <= (nxt != IDLE);
      out_valid <= (nxt == OUT);
      if (state == IDLE && in_valid && in_ready) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      if (state == RD_Y && read_rdy) out_y <= read_data;
      if (timeout_hit) timeout_err <= 1'b1;

      // Bus address/data are decoded from the next state so they are valid for the whole state.
      case (nxt)
        POLL_A:  read_address <= ADDR_W'(REG_A_FULLN);
        POLL_B:  read_address <= ADDR_W'(REG_B_FULLN);
        POLL_Y:  read_address <= ADDR_W'(REG_Y_EMPTYN);
        RD_Y:    read_address <= ADDR_W'(REG_Y_DATA);
        default: read_address <= '0;
      endcase
      case (nxt)
        WR_A: begin
          write_address <= ADDR_W'(REG_A_DATA);
          write_data    <= a_q;
        end
        WR_B: begin
          write_address <= ADDR_W'(REG_B_DATA);
          write_data    <= b_q;
        end
        default: begin
          write_address <= '0;
          write_data    <= '0;
        end
      endcase
    end
  end

`ifdef OR_DRV_CHECK_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      check_err    <= 1'b0;
      mismatch_cnt <= '0;
    end else if (state == RD_Y && read_rdy && (read_data != (a_q | b_q))) begin
      check_err <= 1'b1;
      if (mismatch_cnt != 8'hFF) mismatch_cnt <= mismatch_cnt + 8'd1;
    end
  end
`else
  assign check_err    = 1'b0;
  assign mismatch_cnt = '0;
`endif

endmodule
